// File: rtl/mc_control.sv
// mc_control: multi-cycle instruction control FSM.
// The FSM steps each instruction through IF, ID, EX, MEM and WB, plus an FPX state
// for multi-cycle floating-point execute. It waits on mem_ready in IF and MEM.
// opcode/funct/fmt are captured when the IR is written. Every later state decodes
// only that captured copy, so the IR may change underneath without effect.
// Control outputs are combinational from state, the latched class and mem_ready.
// The datapath can then use them in the same cycle.

module mc_control #(
    parameter int unsigned FP_LAT = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       fmt,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       bclt,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       fp_reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       fp_busy,
    output logic       fp_cond_write,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_FPX = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R    = 4'd0,
        C_JR   = 4'd1,
        C_ADDI = 4'd2,
        C_LW   = 4'd3,
        C_SW   = 4'd4,
        C_LWC1 = 4'd5,
        C_SWC1 = 4'd6,
        C_BEQ  = 4'd7,
        C_BNE  = 4'd8,
        C_J    = 4'd9,
        C_JAL  = 4'd10,
        C_FP   = 4'd11,
        C_BC1T = 4'd12,
        C_ILL  = 4'd13
    } cls_t;

    // FPX counts down from FP_LAT-1 to 0, so FPX lasts exactly FP_LAT cycles.
    localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(FP_LAT - 32'd1);
    localparam logic [CNT_W-1:0] LP_CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(32'd1);

    // Map the latched instruction fields to an instruction class.
    function automatic cls_t decode_cls(input logic [5:0] op, input logic [5:0] fn, input logic fm);
        cls_t c;
        case (op)
            6'b000000: c = (fn == 6'b001000) ? C_JR : C_R;
            6'b001000: c = C_ADDI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b110001: c = C_LWC1;
            6'b111001: c = C_SWC1;
            6'b000100: c = C_BEQ;
            6'b000101: c = C_BNE;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            6'b010001: c = fm ? C_FP : C_BC1T;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_op;
    logic [5:0]       r_fn;
    logic             r_fmt;
    cls_t             w_cls;
    logic             w_fp_cmp;
    logic             w_cnt_zero;

    // Reset leaves opcode/funct at zero, which decodes as R-type sll $0 (a NOP).
    assign w_cls      = decode_cls(r_op, r_fn, r_fmt);
    assign w_fp_cmp   = (r_fn[5:4] == 2'b11);
    assign w_cnt_zero = (r_cnt == LP_CNT_ZERO);
    assign state      = r_state;

    // State register, IR field latches and FP latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IF;
            r_cnt   <= LP_CNT_ZERO;
            r_op    <= 6'd0;
            r_fn    <= 6'd0;
            r_fmt   <= 1'b0;
        end else begin
            case (r_state)
                S_IF: begin
                    if (mem_ready) begin
                        r_op    <= opcode;
                        r_fn    <= funct;
                        r_fmt   <= fmt;
                        r_state <= S_ID;
                    end else begin
                        r_state <= S_IF;
                    end
                end
                S_ID: begin
                    case (w_cls)
                        C_J, C_JAL, C_JR, C_ILL: r_state <= S_IF;
                        C_FP: begin
                            r_cnt   <= LP_CNT_LOAD;
                            r_state <= S_FPX;
                        end
                        default: r_state <= S_EX;
                    endcase
                end
                S_EX: begin
                    case (w_cls)
                        C_R, C_ADDI:                 r_state <= S_WB;
                        C_LW, C_SW, C_LWC1, C_SWC1:  r_state <= S_MEM;
                        default:                     r_state <= S_IF;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        case (w_cls)
                            C_LW, C_LWC1: r_state <= S_WB;
                            default:      r_state <= S_IF;
                        endcase
                    end else begin
                        r_state <= S_MEM;
                    end
                end
                S_WB: r_state <= S_IF;
                S_FPX: begin
                    if (w_cnt_zero) begin
                        r_state <= w_fp_cmp ? S_IF : S_WB;
                    end else begin
                        r_cnt <= r_cnt - LP_CNT_ONE;
                    end
                end
                default: r_state <= S_IF;
            endcase
        end
    end

    // Control outputs decoded from state, latched class and mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        bclt          = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        fp_reg_write  = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        fp_busy       = 1'b0;
        fp_cond_write = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end else begin
                    ir_write  = 1'b0;
                end
            end
            S_ID: begin
                // Branch target (PC + imm<<2) is computed here into ALUOut.
                alu_src_b = 2'b11;
                case (w_cls)
                    C_J: begin
                        pc_write   = 1'b1;
                        pc_source  = 2'b10;
                        instr_done = 1'b1;
                    end
                    C_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = 2'b10;
                        instr_done = 1'b1;
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                    C_JR: begin
                        pc_write   = 1'b1;
                        pc_source  = 2'b11;
                        instr_done = 1'b1;
                    end
                    C_ILL: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: illegal = 1'b0;
                endcase
            end
            S_EX: begin
                case (w_cls)
                    C_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                    end
                    C_ADDI, C_LW, C_SW, C_LWC1, C_SWC1: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                    end
                    C_BEQ, C_BNE: begin
                        alu_src_a     = 1'b1;
                        alu_op        = 2'b01;
                        pc_write_cond = 1'b1;
                        pc_source     = 2'b01;
                        branch_ne     = r_op[0];
                        instr_done    = 1'b1;
                    end
                    C_BC1T: begin
                        pc_write_cond = 1'b1;
                        bclt          = 1'b1;
                        pc_source     = 2'b01;
                        instr_done    = 1'b1;
                    end
                    default: alu_src_a = 1'b0;
                endcase
            end
            S_MEM: begin
                // Address and request strobe held steady until memory answers.
                iord = 1'b1;
                case (w_cls)
                    C_LW, C_LWC1: mem_read = 1'b1;
                    C_SW, C_SWC1: begin
                        mem_write  = 1'b1;
                        instr_done = mem_ready;
                    end
                    default: mem_read = 1'b0;
                endcase
            end
            S_WB: begin
                instr_done = 1'b1;
                case (w_cls)
                    C_R: begin
                        reg_write = 1'b1;
                        reg_dst   = 2'b01;
                    end
                    C_ADDI: reg_write = 1'b1;
                    C_LW: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'b01;
                    end
                    C_LWC1: begin
                        fp_reg_write = 1'b1;
                        mem_to_reg   = 2'b01;
                    end
                    C_FP: begin
                        fp_reg_write = 1'b1;
                        reg_dst      = 2'b01;
                    end
                    default: reg_write = 1'b0;
                endcase
            end
            S_FPX: begin
                fp_busy = 1'b1;
                if (w_cnt_zero && w_fp_cmp) begin
                    fp_cond_write = 1'b1;
                    instr_done    = 1'b1;
                end else begin
                    fp_cond_write = 1'b0;
                end
            end
            default: mem_read = 1'b0;
        endcase
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM: the successor to the single-cycle combinational decoder. Sequences each instruction through fetch, decode, execute, memory and writeback states, and waits on a memory ready handshake. Supports a parametrised multi-cycle floating-point execute latency. Sits between the instruction register and the multi-cycle datapath, which holds PC, IR, MDR, A/B and ALUOut registers.

## Interface
- FP_LAT, 3: FP execute cycles, legal range 1..2^CNT_W-1.
- CNT_W, 4: FP latency counter width.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; sampled only when ir_write=1.
- funct  in  6  IR[5:0]; sampled only when ir_write=1.
- fmt  in  1  IR FP format bit; sampled only when ir_write=1.
- mem_ready  in  1  memory completed the current access this cycle.
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, FPX=5.
- pc_write, pc_write_cond, branch_ne, bclt  out  1 each  PC update controls.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- iord, mem_read, mem_write, ir_write  out  1 each  memory controls.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub/compare, 10 funct.
- reg_write, fp_reg_write  out  1 each  register file write strobes.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- fp_busy, fp_cond_write, instr_done, illegal  out  1 each  status and pulses.

## Operation
- Decode at ir_write latches opcode, funct and fmt into internal registers. Every later state uses only the latched copy.
- Instruction classes:
  - R: opcode 000000, excluding jr.
  - jr: R with funct 001000.
  - addi: 001000.
  - lw: 100011. sw: 101011.
  - lwc1: 110001. swc1: 111001.
  - beq: 000100. bne: 000101.
  - j: 000010. jal: 000011.
  - FP op: 010001 with fmt=1.
  - bc1t: 010001 with fmt=0.
  - Any other opcode is illegal.
- All outputs are combinational from state, latched class and mem_ready. Any output not listed for a state is 0.
- IF: mem_read=1, iord=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=00, alu_src_a=0, alu_src_b=01, alu_op=00; next state ID.
  - Otherwise stay in IF.
- ID: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - j: pc_write=1, pc_source=10, instr_done=1; next IF.
  - jal: as j, plus reg_write=1, reg_dst=10, mem_to_reg=10.
  - jr: pc_write=1, pc_source=11, instr_done=1; next IF.
  - FP op: next FPX; counter loads FP_LAT-1.
  - illegal: illegal=1, instr_done=1; next IF; no write strobes.
  - All other classes: next EX.
- EX:
  - R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB.
  - addi, lw, sw, lwc1, swc1: alu_src_a=1, alu_src_b=10, alu_op=00. addi goes to WB; loads and stores go to MEM.
  - beq/bne: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=opcode[0], instr_done=1; next IF.
  - bc1t: pc_write_cond=1, bclt=1, pc_source=01, instr_done=1; next IF.
- MEM: iord=1. Loads assert mem_read; stores assert mem_write. Strobes hold until mem_ready=1.
  - Loads then go to WB.
  - Stores go to IF with instr_done=1 in the mem_ready cycle.
- WB: instr_done=1; next IF.
  - R: reg_write, reg_dst=01, mem_to_reg=00.
  - addi: reg_write, reg_dst=00, mem_to_reg=00.
  - lw: reg_write, reg_dst=00, mem_to_reg=01.
  - lwc1: fp_reg_write, reg_dst=00, mem_to_reg=01.
  - FP op: fp_reg_write, reg_dst=01, mem_to_reg=00.
- FPX: fp_busy=1; counter decrements each cycle. When counter=0:
  - Compare (funct[5:4]=11): fp_cond_write=1, instr_done=1; next IF.
  - Otherwise: next WB.

## Timing
- Reset: state=IF, counter=0, latched class=illegal-free NOP. Outputs reflect IF, so mem_read=1 and iord=0; all other strobes are 0.
- Reset asserted mid-instruction aborts immediately, with no further strobes.
- Cycle counts with zero memory wait (mem_ready=1 on the first request cycle):
  - j, jal, jr, illegal: 2.
  - beq, bne, bc1t: 3.
  - R, addi, sw: 4.
  - lw, lwc1: 5.
  - FP op: 3+FP_LAT.
  - FP compare: 2+FP_LAT.
- Each cycle mem_ready is low in IF or MEM adds one cycle. Request strobes and addresses stay stable until mem_ready is high.
- instr_done is high for exactly one cycle per instruction, in its last state. The next cycle is always IF.
- With FP_LAT=1, FPX lasts exactly one cycle.

## Test plan
- Reset with rst_n=0 mid-MEM, then release: state=0, mem_read=1, mem_write=0, counter=0; the first fetch proceeds normally.
- lw (100011) with mem_ready=1 always: states 0,1,2,3,4. reg_write=1, mem_to_reg=01 only in state 4; instr_done pulses once.
- sw with mem_ready low for 3 MEM cycles: mem_write=1 and iord=1 held 4 cycles; instr_done on the 4th; no reg_write.
- bne (000101): EX shows pc_write_cond=1, branch_ne=1, pc_source=01, alu_op=01; 3 cycles total.
- FP add (010001, fmt=1, funct=000000) with FP_LAT=3: fp_busy high exactly 3 cycles, then WB with fp_reg_write=1; 6 cycles total. Change opcode mid-FPX and confirm no effect.
- jal, jr (funct 001000) and opcode 111111: each takes 2 cycles. jal writes $31 with mem_to_reg=10; jr sets pc_source=11; 111111 gives illegal=1 with no writes.
